// File: rtl/fifo_word_serializer.sv
// Pops words from the word FIFO and shifts each one out as an async-style frame:
// start bit, FWIDTH data bits LSB first, optional parity bit, stop bit.
module fifo_word_serializer #(
  parameter int FWIDTH       = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              Abort,
  input  logic [FWIDTH-1:0] F_Data,
  input  logic              F_EmptyN,
  output logic              FOutN,
  output logic              SerOut,
  output logic              Busy,
  output logic              WordDone
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FWIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(FWIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t            state, stateNxt;
  logic [FWIDTH-1:0] shReg;
  logic              parAcc;
  logic [CW-1:0]     bitCnt;
  logic [BW-1:0]     baudCnt;
  logic              bitEnd, popReq;
  logic              serNxt, fOutNNxt, wordDoneNxt;

  assign bitEnd = (baudCnt == BAUD_LAST);
  assign popReq = (state == IDLE) && En && F_EmptyN && !Abort;
  assign Busy   = (state != IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (popReq) stateNxt = LOAD;
      LOAD:    stateNxt = START;
      START:   if (bitEnd) stateNxt = DATA;
      DATA:    if (bitEnd && bitCnt == BIT_LAST) stateNxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bitEnd) stateNxt = STOP;
      STOP:    if (bitEnd) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (Abort) stateNxt = IDLE;
  end

  // Line value is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    serNxt = 1'b1;
    case (state)
      START:   serNxt = 1'b0;
      DATA:    serNxt = shReg[0];
      PARITY:  serNxt = parAcc ^ (PARITY_ODD != 0);
      default: serNxt = 1'b1;
    endcase
    if (Abort) serNxt = 1'b1;
    fOutNNxt    = !popReq;
    wordDoneNxt = (state == STOP) && bitEnd && !Abort;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      FOutN    <= 1'b1;
      SerOut   <= 1'b1;
      WordDone <= 1'b0;
      shReg    <= '0;
      parAcc   <= 1'b0;
      bitCnt   <= '0;
      baudCnt  <= '0;
    end else begin
      FOutN    <= fOutNNxt;
      SerOut   <= serNxt;
      WordDone <= wordDoneNxt;
      case (state)
        LOAD: begin
          // FIFO advances its read pointer at this same edge.
          shReg   <= F_Data;
          parAcc  <= ^F_Data;
          bitCnt  <= '0;
          baudCnt <= '0;
        end
        START, PARITY, STOP: baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
        DATA: begin
          baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
          if (bitEnd) begin
            shReg  <= shReg >> 1;
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: baudCnt <= '0;
      endcase
      if (Abort) baudCnt <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: FWIDTH=8, 2 clocks per bit, even parity.
module tb_fifo_word_serializer;

  logic       Clk, Rst, En, Abort;
  logic [7:0] F_Data;
  logic       F_EmptyN, FOutN, SerOut, Busy, WordDone;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:15];
  logic [3:0] rdPtr = '0;
  logic [3:0] wrPtr = '0;
  int popCnt = 0, wdCnt = 0, dblLow = 0, emptyPop = 0;
  logic prevLow = 1'b0;

  assign F_EmptyN = (rdPtr != wrPtr);
  assign F_Data   = mem[rdPtr];

  fifo_word_serializer #(.FWIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Abort(Abort),
    .F_Data(F_Data), .F_EmptyN(F_EmptyN),
    .FOutN(FOutN), .SerOut(SerOut), .Busy(Busy), .WordDone(WordDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // FIFO read side plus pop/pulse bookkeeping
  always @(posedge Clk) begin
    prevLow <= (FOutN === 1'b0);
    if (FOutN === 1'b0) begin
      popCnt <= popCnt + 1;
      if (F_EmptyN) rdPtr <= rdPtr + 1'b1;
      else          emptyPop <= emptyPop + 1;
      if (prevLow)  dblLow <= dblLow + 1;
    end
    if (WordDone === 1'b1) wdCnt <= wdCnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wrPtr] = w;
    wrPtr = wrPtr + 1'b1;
  endtask

  task automatic waitStart(input string tag, input int budget);
    int n = 0;
    while (SerOut !== 1'b0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_start"}, SerOut, 1'b0);
  endtask

  // Called at the negedge of the first start-bit cycle; bits[p] is frame bit p (p0=start, p10=stop).
  task automatic checkFrame(input string tag, input logic [10:0] bits, input int dropEnAt);
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge Clk);
      chk($sformatf("%s_ser[%0d]", tag, i), SerOut, bits[i/2]);
      chk($sformatf("%s_wd[%0d]", tag, i), WordDone, (i == 21));
      if (i == dropEnAt) En = 1'b0;
    end
  endtask

  initial begin
    int p0, w0;
    Rst = 1'b1; En = 1'b0; Abort = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_fout", FOutN, 1'b1);
    chk("rst_ser",  SerOut, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_wd",   WordDone, 1'b0);
    Rst = 1'b0; En = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_fout", FOutN, 1'b1);

    // single word A5: latency then 22-cycle frame
    p0 = popCnt;
    push(8'hA5);
    @(negedge Clk);
    chk("a5_pop_low", FOutN, 1'b0);
    chk("a5_load_ser", SerOut, 1'b1);
    chk("a5_load_busy", Busy, 1'b1);
    @(negedge Clk);
    chk("a5_pop_high", FOutN, 1'b1);
    chk("a5_pre_ser", SerOut, 1'b1);
    @(negedge Clk);
    checkFrame("a5", 11'b101_0100_1010, -1);
    @(negedge Clk);
    chk("a5_after_ser", SerOut, 1'b1);
    chk("a5_after_wd", WordDone, 1'b0);
    chk("a5_after_busy", Busy, 1'b0);
    chk("a5_pops", popCnt - p0, 1);

    // back-to-back 01, FF
    repeat (2) @(negedge Clk);
    p0 = popCnt;
    push(8'h01); push(8'hFF);
    waitStart("b2b1", 6);
    checkFrame("w01", 11'b110_0000_0010, -1);
    @(negedge Clk);
    chk("gap_ser0", SerOut, 1'b1);
    chk("gap_pop", FOutN, 1'b0);
    @(negedge Clk);
    chk("gap_ser1", SerOut, 1'b1);
    chk("gap_pop_end", FOutN, 1'b1);
    @(negedge Clk);
    chk("gap_fall", SerOut, 1'b0);
    checkFrame("wFF", 11'b101_1111_1110, -1);
    repeat (3) @(negedge Clk);
    chk("b2b_pops", popCnt - p0, 2);
    chk("b2b_empty", F_EmptyN, 1'b0);

    // En dropped during data bits of frame 1
    p0 = popCnt;
    push(8'h81); push(8'h3C);
    waitStart("en1", 6);
    checkFrame("w81", 11'b101_0000_0010, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk($sformatf("enoff_fout[%0d]", i), FOutN, 1'b1);
      chk($sformatf("enoff_ser[%0d]", i), SerOut, 1'b1);
    end
    chk("enoff_pops", popCnt - p0, 1);
    chk("enoff_nonempty", F_EmptyN, 1'b1);
    En = 1'b1;
    waitStart("en2", 6);
    checkFrame("w3C", 11'b100_0111_1000, -1);
    @(negedge Clk);
    chk("en_pops", popCnt - p0, 2);

    // Abort in the 4th data bit
    repeat (2) @(negedge Clk);
    w0 = wdCnt;
    push(8'h5A);
    waitStart("ab", 6);
    repeat (7) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    chk("ab_ser", SerOut, 1'b1);
    chk("ab_busy", Busy, 1'b0);
    chk("ab_wd", WordDone, 1'b0);
    Abort = 1'b0;
    repeat (4) @(negedge Clk);
    chk("ab_idle_ser", SerOut, 1'b1);
    chk("ab_no_wd", wdCnt - w0, 0);
    push(8'hC3);
    waitStart("ab2", 6);
    checkFrame("wC3", 11'b101_1000_0110, -1);

    // async reset mid-frame
    repeat (2) @(negedge Clk);
    push(8'h55);
    waitStart("rs", 6);
    repeat (5) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("arst_ser", SerOut, 1'b1);
    chk("arst_fout", FOutN, 1'b1);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_wd", WordDone, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("arst_idle_ser", SerOut, 1'b1);
    chk("arst_idle_busy", Busy, 1'b0);

    // empty FIFO for 50 cycles
    p0 = popCnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      chk($sformatf("empty_fout[%0d]", i), FOutN, 1'b1);
      chk($sformatf("empty_ser[%0d]", i), SerOut, 1'b1);
    end
    chk("empty_pops", popCnt - p0, 0);
    chk("dbl_low", dblLow, 0);
    chk("empty_pop", emptyPop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
